wb_write_arbiter: RTL and testbench

Arbitrates the single register-file write port between the in-order writeback stage and a long-latency result source (multi-cycle MUL/DIV, load-miss return) on each core. Long-latency results are queued in a small FIFO and drained into idle writeback slots. A starvation limit forces a pipeline hold so queued results always retire. The block sits between the WB stage output and the register file write port, one instance per core.

---
 rtl/wb_write_arbiter_if.sv | 27 ++
 rtl/wb_write_arbiter.sv | 166 ++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_arbiter_if.sv
// Bundle for the WB-stage / long-latency result / register-file write port of wb_write_arbiter.
// Handshakes: an lu result transfers on a cycle where lu_valid && lu_ready (sampled at posedge). Once
// lu_valid is high, lu_addr/lu_data stay stable until that cycle. While pipe_stall_req is high, pipe_* stay stable.
interface wb_write_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        pipe_stall_req;
  logic [31:0] busy_mask;

  modport slave (
    input  pipe_we, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
    output lu_ready, rf_we, rf_addr, rf_data, pipe_stall_req, busy_mask
  );

  modport master (
    output pipe_we, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
    input  lu_ready, rf_we, rf_addr, rf_data, pipe_stall_req, busy_mask
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Shares the register-file write port between the in-order WB stage and a queued long-latency source.
// Optional simulation checks and write trace are enabled with the WB_ARB_DEBUG_EN macro.
module wb_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_write_arbiter_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT    = CW'(1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [DEPTH-1:0] live_q;
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [SW-1:0]    starve_q, starve_d;
  logic             stall_q, stall_d;

  logic        empty, full, pipe_eff, grant_pipe, pop, push;
  logic        rf_we_c;
  logic [4:0]  rf_addr_c;
  logic [31:0] rf_data_c;
  logic [31:0] busy_c;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_CNT);
  assign pipe_eff   = bus.pipe_we && (bus.pipe_addr != 5'd0);
  assign grant_pipe = !stall_q && pipe_eff;
  assign pop        = !grant_pipe && !empty;
  // x0 results complete the handshake but never occupy a slot.
  assign push       = bus.lu_valid && !full && (bus.lu_addr != 5'd0);

  // Write-port mux; forced quiet while reset is held so a live pipe_we cannot leak through.
  always_comb begin
    rf_we_c   = 1'b0;
    rf_addr_c = 5'd0;
    rf_data_c = 32'd0;
    if (rst_n) begin
      if (grant_pipe) begin
        rf_we_c   = 1'b1;
        rf_addr_c = bus.pipe_addr;
        rf_data_c = bus.pipe_data;
      end else if (pop) begin
        rf_we_c   = live_q[rd_ptr_q];
        rf_addr_c = addr_q[rd_ptr_q];
        rf_data_c = data_q[rd_ptr_q];
      end
    end
  end

  always_comb begin
    busy_c = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) busy_c[addr_q[i]] = 1'b1;
    end
  end

  assign bus.lu_ready       = !full;
  assign bus.rf_we          = rf_we_c;
  assign bus.rf_addr        = rf_addr_c;
  assign bus.rf_data        = rf_data_c;
  assign bus.pipe_stall_req = stall_q;
  assign bus.busy_mask      = busy_c;

  // Counts consecutive cycles a non-empty queue was passed over by the pipeline.
  always_comb begin
    starve_d = starve_q;
    if (pop || empty) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (pop && (count_q == ONE_CNT)) begin
      stall_d = 1'b0;
    end else if (starve_d == STARVE_MAX) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + ONE_CNT;
        2'b01:   count_q <= count_q - ONE_CNT;
        default: count_q <= count_q;
      endcase
    end
  end

  // Kill runs before the push write so an entry enqueued this cycle survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      if (grant_pipe) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (addr_q[i] == bus.pipe_addr) live_q[i] <= 1'b0;
        end
      end
      if (pop) live_q[rd_ptr_q] <= 1'b0;
      if (push) begin
        live_q[wr_ptr_q] <= 1'b1;
        addr_q[wr_ptr_q] <= bus.lu_addr;
        data_q[wr_ptr_q] <= bus.lu_data;
      end
    end
  end

`ifdef WB_ARB_DEBUG_EN
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  string       dbg_src;
  logic        hold_pipe_q = 1'b0;
  logic        hold_lu_q   = 1'b0;
  logic [4:0]  pa_q, la_q;
  logic [31:0] pd_q, ld_q;

  always @(posedge clk) begin
    if (rst_n && rf_we_c) begin
      dbg_addr = rf_addr_c;
      dbg_data = rf_data_c;
      dbg_src  = grant_pipe ? "PIPE" : "LU";
      $strobe("WB_ARB: x%0d <= %08h (%s)", dbg_addr, dbg_data, dbg_src);
    end
    if (rst_n && hold_pipe_q &&
        (bus.pipe_we !== 1'b1 || bus.pipe_addr !== pa_q || bus.pipe_data !== pd_q))
      $error("WB_ARB: pipe_* changed while pipe_stall_req held");
    if (rst_n && hold_lu_q && bus.lu_valid &&
        (bus.lu_addr !== la_q || bus.lu_data !== ld_q))
      $error("WB_ARB: lu_addr/lu_data changed before acceptance");
    hold_pipe_q = rst_n && stall_q && bus.pipe_we;
    hold_lu_q   = rst_n && bus.lu_valid && !bus.lu_ready;
    pa_q = bus.pipe_addr;
    pd_q = bus.pipe_data;
    la_q = bus.lu_addr;
    ld_q = bus.lu_data;
  end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios plus random traffic against a queue model.
module tb_wb_write_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_write_arbiter_if bus();

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: queued results as {live, addr, data}
  logic [37:0] exp_q[$];
  int          m_starve = 0;
  logic        m_stall  = 1'b0;
  logic        m_lu_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.pipe_we   = pwe;
    bus.pipe_addr = pa;
    bus.pipe_data = pd;
    bus.lu_valid  = lv;
    bus.lu_addr   = la;
    bus.lu_data   = ld;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_starve  = 0;
    m_stall   = 1'b0;
    m_lu_pend = 1'b0;
  endtask

  // Predict this cycle's outputs from the queue, compare, then advance the model past the edge.
  task automatic model_cycle();
    int          sz;
    logic        eff, grant, popped, accepted, e_we;
    logic [4:0]  ea;
    logic [31:0] ed, eb;
    logic [37:0] tmp;
    sz = exp_q.size();
    eff = bus.pipe_we && (bus.pipe_addr != 5'd0);
    grant = !m_stall && eff;
    popped = !grant && (sz > 0);
    eb = 32'd0;
    foreach (exp_q[i]) if (exp_q[i][37]) eb[exp_q[i][36:32]] = 1'b1;
    e_we = 1'b0; ea = 5'd0; ed = 32'd0;
    if (grant) begin
      e_we = 1'b1; ea = bus.pipe_addr; ed = bus.pipe_data;
    end else if (popped) begin
      e_we = exp_q[0][37]; ea = exp_q[0][36:32]; ed = exp_q[0][31:0];
    end
    check("lu_ready", bus.lu_ready, sz < DEPTH);
    check("stall_req", bus.pipe_stall_req, m_stall);
    check("busy_mask", bus.busy_mask, eb);
    check("rf_we", bus.rf_we, e_we);
    if (e_we) begin
      check("rf_addr", bus.rf_addr, ea);
      check("rf_data", bus.rf_data, ed);
    end
    accepted = bus.lu_valid && (sz < DEPTH);
    if (grant) begin
      foreach (exp_q[i]) begin
        if (exp_q[i][36:32] == bus.pipe_addr) begin
          tmp = exp_q[i]; tmp[37] = 1'b0; exp_q[i] = tmp;
        end
      end
    end
    if (popped) void'(exp_q.pop_front());
    if (popped || sz == 0) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    if (popped && sz == 1) m_stall = 1'b0;
    else if (m_starve == LIMIT) m_stall = 1'b1;
    if (accepted && bus.lu_addr != 5'd0) exp_q.push_back({1'b1, bus.lu_addr, bus.lu_data});
    m_lu_pend = bus.lu_valid && !accepted;
  endtask

  task automatic step(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld);
    @(negedge clk);
    drive(pwe, pa, pd, lv, la, ld);
    #1;
    model_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_we"}, bus.rf_we, 1'b0);
    check({tag, "_rf_addr"}, bus.rf_addr, 5'd0);
    check({tag, "_rf_data"}, bus.rf_data, 32'd0);
    check({tag, "_lu_ready"}, bus.lu_ready, 1'b1);
    check({tag, "_stall"}, bus.pipe_stall_req, 1'b0);
    check({tag, "_busy"}, bus.busy_mask, 32'd0);
  endtask

  initial begin
    int          n_stall, n_denied, n_pop;
    logic        c_pwe, c_lv;
    logic [4:0]  c_pa, c_la;
    logic [31:0] c_pd, c_ld;

    // reset with a live pipeline write presented
    drive(1'b1, 5'd3, 32'h0BAD0BAD, 1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b1;
    model_reset();

    // idle pipe: x5 arrives one cycle after acceptance
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11111111);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("idle_rf_we", bus.rf_we, 1'b1);
    check("idle_rf_addr", bus.rf_addr, 5'd5);
    check("idle_rf_data", bus.rf_data, 32'h11111111);
    check("idle_busy5_set", bus.busy_mask[5], 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("idle_busy5_clr", bus.busy_mask[5], 1'b0);

    // fill under continuous x1 pipeline writes
    n_stall = 0; n_denied = 0; n_pop = 0;
    for (int c = 0; c < 40; c++) begin
      step(1'b1, 5'd1, 32'h1111_0001, c < 4, 5'(c + 2), 32'hF0 + 32'(c));
      if (c == 4) check("fill_ready_full", bus.lu_ready, 1'b0);
      if (bus.pipe_stall_req) n_stall++;
      if (bus.rf_we && bus.rf_addr == 5'd1 && bus.busy_mask != 32'd0) n_denied++;
      if (bus.rf_we && bus.rf_addr != 5'd1) n_pop++;
      if (c > 4 && !bus.pipe_stall_req && bus.rf_we && bus.rf_addr == 5'd1 && bus.busy_mask == 32'd0) break;
    end
    check("fill_denied", n_denied, 8);
    check("fill_stall_cycles", n_stall, 4);
    check("fill_pops", n_pop, 4);
    check("fill_pipe_granted", bus.rf_data, 32'h1111_0001);

    // stale kill of x7
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAAAA0000);
    step(1'b1, 5'd7, 32'h0000BBBB, 1'b0, 5'd0, 32'd0);
    check("kill_rf_addr", bus.rf_addr, 5'd7);
    check("kill_rf_data", bus.rf_data, 32'h0000BBBB);
    check("kill_busy7_before", bus.busy_mask[7], 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("kill_pop_we", bus.rf_we, 1'b0);
    check("kill_busy7_after", bus.busy_mask[7], 1'b0);

    // x0 filtering on both sides
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEADBEEF);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("x0_lu_nothing", bus.rf_we, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33333333);
    step(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0);
    check("x0_pipe_pop_addr", bus.rf_addr, 5'd3);
    check("x0_pipe_pop_data", bus.rf_data, 32'h33333333);

    // simultaneous push/pop at count 2
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd8, 32'h80);
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h90);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA0);
    step(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'd0);
    check("pushpop_busy", bus.busy_mask, 32'h0000_0600);
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // pointer wrap: data 0..9 must emerge in order
    for (int i = 0; i <= 10; i++) begin
      step(1'b0, 5'd0, 32'd0, i < 10, 5'(12 + (i % 4)), 32'(i));
      if (i > 0) check("wrap_data", bus.rf_data, 32'(i - 1));
    end

    // reset with three entries queued and stall asserted
    for (int c = 0; c < 20 && !bus.pipe_stall_req; c++)
      step(1'b1, 5'd1, 32'h2, c < 3, 5'(20 + c), 32'(c));
    check("rst_pre_stall", bus.pipe_stall_req, 1'b1);
    check("rst_pre_busy", bus.busy_mask, 32'h0070_0000);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b1;

    // random traffic honouring the hold rules
    c_pwe = 1'b0; c_pa = 5'd0; c_pd = 32'd0; c_lv = 1'b0; c_la = 5'd0; c_ld = 32'd0;
    for (int n = 0; n < 600; n++) begin
      if (!(m_stall && c_pwe)) begin
        c_pwe = ($urandom_range(0, 9) < 7);
        c_pa  = 5'($urandom_range(0, 7));
        c_pd  = $urandom;
      end
      if (!m_lu_pend) begin
        c_lv = ($urandom_range(0, 9) < 5);
        c_la = 5'($urandom_range(0, 7));
        c_ld = $urandom;
      end
      step(c_pwe, c_pa, c_pd, c_lv, c_la, c_ld);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
